// File: rtl/cacheline_adaptor.sv
// Cache line <-> memory burst adaptor.
// Splits a dirty line into BEAT_W-wide write beats, or assembles read beats
// into a refill line. One burst per request, paced by resp_i.
module cacheline_adaptor #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [31:0]       pmem_address,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic [31:0]       address_o,
    output logic              read_o,
    output logic              write_o,
    output logic [BEAT_W-1:0] burst_o,
    input  logic [BEAT_W-1:0] burst_i,
    input  logic              resp_i
);

    localparam int unsigned BEATS = LINE_W / BEAT_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LINE_BYTES = LINE_W / 8;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
    localparam logic [31:0] ADDR_MASK = ~(32'(LINE_BYTES - 1));

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [CNT_W-1:0]  cnt;
    logic [LINE_W-1:0] wbuf;

    logic beat_c;
    logic last_beat_c;

    assign beat_c      = resp_i && ((state == RD) || (state == WR));
    assign last_beat_c = beat_c && (cnt == LAST);

    // Write beats leave from the bottom of the shift buffer.
    assign burst_o = wbuf[BEAT_W-1:0];

    // Next-state decode; write wins over read when both are requested.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pmem_write) begin
                    state_next = WR;
                end else if (pmem_read) begin
                    state_next = RD;
                end
            end
            RD, WR: begin
                if (last_beat_c) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and state-decoded handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            pmem_resp <= 1'b0;
        end else begin
            state     <= state_next;
            read_o    <= (state_next == RD);
            write_o   <= (state_next == WR);
            pmem_resp <= (state_next == DONE);
        end
    end

    // Request capture, beat counter, refill assembly and writeback shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            address_o  <= '0;
            wbuf       <= '0;
            pmem_rdata <= '0;
        end else begin
            if (state == IDLE && (pmem_write || pmem_read)) begin
                address_o <= pmem_address & ADDR_MASK;
                cnt       <= '0;
                if (pmem_write) begin
                    wbuf <= pmem_wdata;
                end
            end
            if (beat_c) begin
                cnt <= last_beat_c ? '0 : cnt + CNT_W'(1);
                if (state == RD) begin
                    pmem_rdata[BEAT_W*int'(cnt) +: BEAT_W] <= burst_i;
                end else begin
                    wbuf <= wbuf >> BEAT_W;
                end
            end
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: read, write, gapped, priority,
// mid-burst reset and back-to-back bursts.
module tb_cacheline_adaptor;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned BEAT_W = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              pmem_read = 1'b0;
    logic              pmem_write = 1'b0;
    logic [31:0]       pmem_address = '0;
    logic [LINE_W-1:0] pmem_wdata = '0;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic [31:0]       address_o;
    logic              read_o;
    logic              write_o;
    logic [BEAT_W-1:0] burst_o;
    logic [BEAT_W-1:0] burst_i = '0;
    logic              resp_i = 1'b0;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int t0       = 0;

    localparam logic [BEAT_W-1:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    cacheline_adaptor #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .address_o    (address_o),
        .read_o       (read_o),
        .write_o      (write_o),
        .burst_o      (burst_o),
        .burst_i      (burst_i),
        .resp_i       (resp_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LINE_W-1:0] got,
                         input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One request cycle, then drop the request lines.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [LINE_W-1:0] wd);
        t0           = cyc;
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = a;
        pmem_wdata   = wd;
        step();
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 32'hFFFF_FFFF;
    endtask

    // Drive a resp_i pattern (bit i = cycle i); check handshake, address and write beats.
    task automatic feed(input logic [BEAT_W-1:0] b [4], input logic [15:0] pat,
                        input int plen, input bit is_wr, input logic [31:0] exp_addr);
        int k = 0;
        for (int i = 0; i < plen; i++) begin
            if (is_wr) begin
                check("write_o_busy", LINE_W'(write_o), LINE_W'(1'b1));
                check("read_o_in_wr", LINE_W'(read_o), LINE_W'(1'b0));
                if (k < 4) check("burst_o", LINE_W'(burst_o), LINE_W'(b[k]));
            end else begin
                check("read_o_busy", LINE_W'(read_o), LINE_W'(1'b1));
                check("write_o_in_rd", LINE_W'(write_o), LINE_W'(1'b0));
            end
            check("address_o_hold", LINE_W'(address_o), LINE_W'(exp_addr));
            check("resp_busy", LINE_W'(pmem_resp), LINE_W'(1'b0));
            resp_i  = pat[i];
            burst_i = (pat[i] && !is_wr && k < 4) ? b[k] : JUNK;
            step();
            if (pat[i]) k++;
        end
        resp_i  = 1'b0;
        burst_i = JUNK;
    endtask

    // Expect the DONE cycle now, with the given latency, then a single pulse.
    task automatic expect_done(input int lat);
        check("resp_done", LINE_W'(pmem_resp), LINE_W'(1'b1));
        check("read_o_done", LINE_W'(read_o), LINE_W'(1'b0));
        check("write_o_done", LINE_W'(write_o), LINE_W'(1'b0));
        check("latency", LINE_W'(cyc - t0), LINE_W'(lat));
        step();
        check("resp_single", LINE_W'(pmem_resp), LINE_W'(1'b0));
    endtask

    logic [BEAT_W-1:0] rb [4];
    logic [BEAT_W-1:0] wb [4];
    logic [BEAT_W-1:0] rb2 [4];
    logic [LINE_W-1:0] rline;
    logic [LINE_W-1:0] rline2;
    logic [LINE_W-1:0] wline;

    initial begin
        rb[0] = 64'h1111_1111_1111_1111;
        rb[1] = 64'h2222_2222_2222_2222;
        rb[2] = 64'h3333_3333_3333_3333;
        rb[3] = 64'h4444_4444_4444_4444;
        rline = {rb[3], rb[2], rb[1], rb[0]};
        wb[0] = 64'hAAAA_0000_0000_000A;
        wb[1] = 64'hBBBB_0000_0000_000B;
        wb[2] = 64'hCCCC_0000_0000_000C;
        wb[3] = 64'hDDDD_0000_0000_000D;
        wline = {wb[3], wb[2], wb[1], wb[0]};
        rb2[0] = 64'h0123_4567_89AB_CDEF;
        rb2[1] = 64'hFEDC_BA98_7654_3210;
        rb2[2] = 64'h5555_AAAA_5555_AAAA;
        rb2[3] = 64'h0F0F_F0F0_0F0F_F0F0;
        rline2 = {rb2[3], rb2[2], rb2[1], rb2[0]};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_read_o", LINE_W'(read_o), LINE_W'(1'b0));
        check("rst_write_o", LINE_W'(write_o), LINE_W'(1'b0));
        check("rst_resp", LINE_W'(pmem_resp), LINE_W'(1'b0));
        check("rst_addr", LINE_W'(address_o), LINE_W'(32'h0));
        check("rst_rdata", pmem_rdata, '0);
        check("rst_burst_o", LINE_W'(burst_o), LINE_W'(64'h0));
        step();
        step();
        rst_n = 1'b1;
        step();

        // Plain read, back-to-back beats
        issue(1'b1, 1'b0, 32'h0000_1234, '0);
        check("rd_addr", LINE_W'(address_o), LINE_W'(32'h0000_1220));
        feed(rb, 16'b1111, 4, 1'b0, 32'h0000_1220);
        check("rd_line", pmem_rdata, rline);
        expect_done(5);
        check("rd_line_hold", pmem_rdata, rline);

        // Plain write
        issue(1'b0, 1'b1, 32'h0000_ABCF, wline);
        check("wr_addr", LINE_W'(address_o), LINE_W'(32'h0000_ABC0));
        feed(wb, 16'b1111, 4, 1'b1, 32'h0000_ABC0);
        expect_done(5);
        check("wr_keeps_rdata", pmem_rdata, rline);

        // Gapped read: resp_i 1,0,0,1,1,0,1
        issue(1'b1, 1'b0, 32'h0000_2040, '0);
        feed(rb2, 16'b1011001, 7, 1'b0, 32'h0000_2040);
        check("gap_line", pmem_rdata, rline2);
        expect_done(8);

        // Gapped write: burst_o must stall on gaps
        issue(1'b0, 1'b1, 32'h0000_3000, wline);
        feed(wb, 16'b1011001, 7, 1'b1, 32'h0000_3000);
        expect_done(8);

        // Read and write together: write wins
        issue(1'b1, 1'b1, 32'h0000_4000, wline);
        feed(wb, 16'b1111, 4, 1'b1, 32'h0000_4000);
        expect_done(5);
        check("both_rdata_untouched", pmem_rdata, rline2);

        // Reset after two read beats aborts the burst
        issue(1'b1, 1'b0, 32'h0000_5000, '0);
        feed(rb, 16'b0011, 2, 1'b0, 32'h0000_5000);
        rst_n = 1'b0;
        #1;
        check("abort_read_o", LINE_W'(read_o), LINE_W'(1'b0));
        check("abort_resp", LINE_W'(pmem_resp), LINE_W'(1'b0));
        check("abort_addr", LINE_W'(address_o), LINE_W'(32'h0));
        check("abort_rdata", pmem_rdata, '0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_resp", LINE_W'(pmem_resp), LINE_W'(1'b0));
            check("abort_idle_read", LINE_W'(read_o), LINE_W'(1'b0));
        end
        issue(1'b1, 1'b0, 32'h0000_601F, '0);
        feed(rb, 16'b1111, 4, 1'b0, 32'h0000_6000);
        check("after_abort_line", pmem_rdata, rline);
        expect_done(5);

        // Stray resp_i in IDLE is ignored
        resp_i  = 1'b1;
        burst_i = JUNK;
        step();
        step();
        resp_i = 1'b0;
        check("stray_rdata", pmem_rdata, rline);
        check("stray_resp", LINE_W'(pmem_resp), LINE_W'(1'b0));
        check("stray_read_o", LINE_W'(read_o), LINE_W'(1'b0));

        // Back-to-back read then write, with resp_i held through DONE
        issue(1'b1, 1'b0, 32'h0000_7000, '0);
        feed(rb2, 16'b1111, 4, 1'b0, 32'h0000_7000);
        check("b2b_rd_line", pmem_rdata, rline2);
        check("b2b_done", LINE_W'(pmem_resp), LINE_W'(1'b1));
        resp_i  = 1'b1;
        burst_i = JUNK;
        step();
        resp_i = 1'b0;
        check("b2b_idle_resp", LINE_W'(pmem_resp), LINE_W'(1'b0));
        issue(1'b0, 1'b1, 32'h0000_8000, wline);
        check("b2b_wr_start", LINE_W'(write_o), LINE_W'(1'b1));
        feed(wb, 16'b1111, 4, 1'b1, 32'h0000_8000);
        expect_done(5);
        check("b2b_rdata_kept", pmem_rdata, rline2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk (rising edge), rst_n.
REQ-002 The block SHALL have parameter LINE_W, default 256, giving the cache line width in bits.
REQ-003 The block SHALL have parameter BEAT_W, default 64, giving the memory burst beat width; BEATS = LINE_W/BEAT_W (default 4, power of 2).
REQ-004 The block SHALL have port clk, input, 1, system clock.
REQ-005 The block SHALL have port rst_n, input, 1, async active-low reset.
REQ-006 The block SHALL have port pmem_read, input, 1, line read request from cache controller.
REQ-007 The block SHALL have port pmem_write, input, 1, line writeback request from cache controller.
REQ-008 The block SHALL have port pmem_address, input, 32, line address from cache.
REQ-009 The block SHALL have port pmem_wdata, input, LINE_W, dirty line to write back.
REQ-010 The block SHALL have port pmem_rdata, output, LINE_W, assembled refill line.
REQ-011 The block SHALL have port pmem_resp, output, 1, one-cycle completion pulse to cache.
REQ-012 The block SHALL have port address_o, output, 32, line-aligned burst address.
REQ-013 The block SHALL have port read_o / write_o, output, 1 each, burst read / burst write request to memory.
REQ-014 The block SHALL have port burst_o, output, BEAT_W, current write beat.
REQ-015 The block SHALL have port burst_i, input, BEAT_W, current read beat.
REQ-016 The block SHALL have port resp_i, input, 1, memory beat acknowledge (one beat per asserted cycle).

Function
REQ-017 The block SHALL implement FSM states IDLE, RD, WR, DONE.
REQ-018 In IDLE, pmem_write=1 SHALL capture pmem_wdata and address, clear beat counter, go to WR; else pmem_read=1 SHALL capture address, clear counter, go to RD; write wins if both high.
REQ-019 Captured address SHALL be line-aligned: address_o = {pmem_address[31:log2(LINE_W/8)], zeros}; address_o SHALL hold stable for the entire burst.
REQ-020 In RD, read_o SHALL be 1; each cycle with resp_i=1 SHALL store burst_i into line bits [BEAT_W*k +: BEAT_W], k = counter, then increment counter.
REQ-021 In WR, write_o SHALL be 1 and burst_o SHALL equal captured line bits [BEAT_W*k +: BEAT_W]; each resp_i=1 cycle SHALL increment counter.
REQ-022 resp_i may have gaps (resp_i=0 cycles) mid-burst; counter and outputs SHALL hold during gaps.
REQ-023 On the resp_i cycle with counter = BEATS-1, the FSM SHALL go to DONE; counter SHALL wrap to 0; read_o/write_o SHALL be 0 from the next cycle.
REQ-024 In DONE, pmem_resp SHALL be 1 for exactly one cycle, pmem_rdata SHALL be valid, then FSM SHALL return to IDLE.
REQ-025 pmem_rdata SHALL hold the last assembled line until the next read burst overwrites beats.
REQ-026 resp_i in IDLE or DONE SHALL be ignored; pmem_read/pmem_write changes during RD/WR SHALL be ignored.
REQ-027 Minimum latency: request in IDLE at cycle 0, back-to-back resp_i cycles 1..BEATS, pmem_resp at cycle BEATS+1.
REQ-028 Outputs read_o, write_o, pmem_resp SHALL be decoded from state only (no combinational path from inputs).

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, counter 0, read_o=0, write_o=0, pmem_resp=0, address_o=0, pmem_rdata=0, write buffer=0.
REQ-030 rst_n assertion mid-burst SHALL abort the burst with no pmem_resp; after release the block SHALL accept a new request in IDLE.

Verification
REQ-031 Read: pmem_read=1, pmem_address=0x0000_1234; resp_i 4 consecutive cycles with burst_i=0x11..,0x22..,0x33..,0x44.. -> address_o=0x0000_1220, pmem_rdata={0x44..,0x33..,0x22..,0x11..}, pmem_resp one cycle, 5 cycles after request.
REQ-032 Write: pmem_write=1, pmem_wdata=line of beats A,B,C,D (beat0=A) -> write_o=1, burst_o A,B,C,D on successive resp_i cycles, write_o=0 after 4th, single pmem_resp.
REQ-033 Gapped resp_i: read with resp_i pattern 1,0,0,1,1,0,1 -> beats land in order 0..3, burst_o/counter stall on gaps, pmem_resp after 7th cycle.
REQ-034 Both pmem_read and pmem_write=1 in IDLE -> WR taken, read_o stays 0.
REQ-035 rst_n pulsed low after 2 read beats -> read_o=0 immediately, no pmem_resp; subsequent full read returns correct line.
REQ-036 Back-to-back read then write requests -> second burst starts the cycle after DONE; no stray resp_i effect in IDLE.
